uart_cmd_decoder: RTL and testbench

Receive-side command parser for the UART link. Consumes bytes delivered by the UART receiver (RX_Data_out / RX_Data_Ready), finds and validates framed host commands, and writes payload bytes into a small external buffer. Counterpart to the host-side framer that writes commands into the link. Sits between the UART RX path and the control/register logic.

---
 rtl/uart_cmd_decoder_if.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 133 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / frame-out bundle between the UART receiver, the command decoder
// and the payload buffer plus control logic that consume its results.
interface uart_cmd_decoder_if;
  logic [7:0] RX_Data_in;
  logic       RX_Data_Ready;
  logic [7:0] Cmd_out;
  logic [7:0] Len_out;
  logic [7:0] Payload_addr;
  logic [7:0] Payload_data;
  logic       Payload_we;
  logic       Frame_valid;
  logic       Frame_error;
  logic [1:0] Error_code;
  logic       Busy;

  modport slave (
    input  RX_Data_in, RX_Data_Ready,
    output Cmd_out, Len_out, Payload_addr, Payload_data, Payload_we,
           Frame_valid, Frame_error, Error_code, Busy
  );

  modport master (
    output RX_Data_in, RX_Data_Ready,
    input  Cmd_out, Len_out, Payload_addr, Payload_data, Payload_we,
           Frame_valid, Frame_error, Error_code, Busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/CMD/LEN/payload/CHK frames from the UART receive byte stream,
// writes payload bytes to an external buffer and reports frame accept/reject.
module uart_cmd_decoder #(
  parameter int MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input logic clk,
  input logic reset,
  uart_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHECK
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t                   state;
  logic                     ready_d;
  logic [7:0]               acc;
  logic [7:0]               idx;
  logic [7:0]               cmd_sh;
  logic [7:0]               len_sh;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic                     strobe;

  // ready_d resets high so a level already asserted at reset release is not a byte.
  assign strobe = bus.RX_Data_Ready & ~ready_d;

  always_ff @(posedge clk) begin
    state_t nxt;
    if (reset) begin
      state            <= IDLE;
      ready_d          <= 1'b1;
      acc              <= '0;
      idx              <= '0;
      cmd_sh           <= '0;
      len_sh           <= '0;
      tcnt             <= '0;
      bus.Cmd_out      <= '0;
      bus.Len_out      <= '0;
      bus.Payload_addr <= '0;
      bus.Payload_data <= '0;
      bus.Payload_we   <= 1'b0;
      bus.Frame_valid  <= 1'b0;
      bus.Frame_error  <= 1'b0;
      bus.Error_code   <= '0;
      bus.Busy         <= 1'b0;
    end else begin
      nxt = state;
      ready_d         <= bus.RX_Data_Ready;
      bus.Payload_we  <= 1'b0;
      bus.Frame_valid <= 1'b0;
      bus.Frame_error <= 1'b0;

      // A strobe always restarts the inter-byte timer, so it beats a coincident timeout.
      if (state == IDLE || strobe) begin
        tcnt <= '0;
      end else if (tcnt == TIMEOUT_LAST) begin
        tcnt            <= '0;
        bus.Frame_error <= 1'b1;
        bus.Error_code  <= 2'b11;
        nxt = IDLE;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (strobe) begin
        unique case (state)
          IDLE: begin
            if (bus.RX_Data_in == SYNC_BYTE) begin
              acc <= '0;
              idx <= '0;
              nxt = CMD;
            end
          end
          CMD: begin
            cmd_sh <= bus.RX_Data_in;
            acc    <= acc + bus.RX_Data_in;
            nxt = LEN;
          end
          LEN: begin
            if (bus.RX_Data_in > MAX_LEN_B) begin
              bus.Frame_error <= 1'b1;
              bus.Error_code  <= 2'b01;
              nxt = IDLE;
            end else if (bus.RX_Data_in == 8'd0) begin
              len_sh <= '0;
              nxt = CHECK;
            end else begin
              len_sh <= bus.RX_Data_in;
              acc    <= acc + bus.RX_Data_in;
              nxt = PAYLOAD;
            end
          end
          PAYLOAD: begin
            bus.Payload_we   <= 1'b1;
            bus.Payload_addr <= idx;
            bus.Payload_data <= bus.RX_Data_in;
            acc              <= acc + bus.RX_Data_in;
            idx              <= idx + 8'd1;
            if (idx == len_sh - 8'd1) begin
              nxt = CHECK;
            end
          end
          CHECK: begin
            if (bus.RX_Data_in == acc) begin
              bus.Frame_valid <= 1'b1;
              bus.Cmd_out     <= cmd_sh;
              bus.Len_out     <= len_sh;
            end else begin
              bus.Frame_error <= 1'b1;
              bus.Error_code  <= 2'b10;
            end
            nxt = IDLE;
          end
          default: nxt = IDLE;
        endcase
      end

      state    <= nxt;
      bus.Busy <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected buffer
// writes and frame results, a negedge monitor pops and compares them.
module tb_uart_cmd_decoder;

  localparam int TIMEOUT_CYCLES = 50;

  typedef enum int {EV_WRITE, EV_VALID, EV_ERROR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  uart_cmd_decoder_if bus();

  ev_t        expQ[$];
  logic [7:0] seq[$];
  logic [7:0] expCmd = 8'h00;
  logic [7:0] expLen = 8'h00;
  int         checks = 0;
  int         errors = 0;

  uart_cmd_decoder #(
    .MAX_LEN(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH(17)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic pushWrite(input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = EV_WRITE; e.a = addr; e.b = data; e.code = 2'b00;
    expQ.push_back(e);
  endtask

  task automatic pushValid(input logic [7:0] cmd, input logic [7:0] len);
    ev_t e;
    expCmd = cmd;
    expLen = len;
    e.kind = EV_VALID; e.a = cmd; e.b = len; e.code = 2'b00;
    expQ.push_back(e);
  endtask

  task automatic pushError(input logic [1:0] code);
    ev_t e;
    e.kind = EV_ERROR; e.a = expCmd; e.b = expLen; e.code = code;
    expQ.push_back(e);
  endtask

  // One byte: rising edge of RX_Data_Ready, then one low cycle.
  task automatic applyStimulus(input logic [7:0] b);
    bus.RX_Data_in    = b;
    bus.RX_Data_Ready = 1'b1;
    @(posedge clk); #1;
    bus.RX_Data_Ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sendSeq();
    foreach (seq[i]) applyStimulus(seq[i]);
  endtask

  task automatic checkEqual(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input ev_kind_t kind, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] code);
    ev_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d a=%h b=%h code=%b, expected none",
               kind, a, b, code);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b || e.code !== code) begin
        errors++;
        $display("[TB] FAIL event: got kind=%0d a=%h b=%h code=%b, expected kind=%0d a=%h b=%h code=%b",
                 kind, a, b, code, e.kind, e.a, e.b, e.code);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.Payload_we)  checkOutput(EV_WRITE, bus.Payload_addr, bus.Payload_data, 2'b00);
      if (bus.Frame_valid) checkOutput(EV_VALID, bus.Cmd_out, bus.Len_out, 2'b00);
      if (bus.Frame_error) checkOutput(EV_ERROR, bus.Cmd_out, bus.Len_out, bus.Error_code);
    end
  end

  task automatic checkAllZero(input string tag);
    checkEqual({tag, "_cmd"},   32'(bus.Cmd_out), 32'h0);
    checkEqual({tag, "_len"},   32'(bus.Len_out), 32'h0);
    checkEqual({tag, "_code"},  32'(bus.Error_code), 32'h0);
    checkEqual({tag, "_we"},    32'(bus.Payload_we), 32'h0);
    checkEqual({tag, "_valid"}, 32'(bus.Frame_valid), 32'h0);
    checkEqual({tag, "_error"}, 32'(bus.Frame_error), 32'h0);
    checkEqual({tag, "_busy"},  32'(bus.Busy), 32'h0);
    checkEqual({tag, "_addr"},  32'(bus.Payload_addr), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    reset             = 1'b1;
    bus.RX_Data_in    = 8'h00;
    bus.RX_Data_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkAllZero("reset");

    pushWrite(8'h00, 8'h10); pushWrite(8'h01, 8'h20); pushValid(8'h01, 8'h02);
    seq = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}; sendSeq();

    pushValid(8'h07, 8'h00);
    seq = '{8'hA5, 8'h07, 8'h00, 8'h07}; sendSeq();

    pushValid(8'h07, 8'h00);
    seq = '{8'h00, 8'hA5, 8'h07, 8'h00, 8'h07}; sendSeq();

    pushWrite(8'h00, 8'h55); pushError(2'b10);
    seq = '{8'hA5, 8'h01, 8'h01, 8'h55, 8'h00}; sendSeq();

    pushError(2'b01);
    seq = '{8'hA5, 8'h02, 8'h11}; sendSeq();

    // Sync byte in payload is data: 05+01+A5 = AB.
    pushWrite(8'h00, 8'hA5); pushValid(8'h05, 8'h01);
    seq = '{8'hA5, 8'h05, 8'h01, 8'hA5, 8'hAB}; sendSeq();

    // Idle after CMD: error must appear exactly TIMEOUT_CYCLES edges after the CMD strobe.
    pushError(2'b11);
    seq = '{8'hA5, 8'h03}; sendSeq();
    cnt = 1;
    while (bus.Frame_error !== 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkEqual("timeout_latency", 32'(cnt), 32'(TIMEOUT_CYCLES));
    @(posedge clk); #1;
    checkEqual("timeout_busy", 32'(bus.Busy), 32'h0);
    checkEqual("timeout_code", 32'(bus.Error_code), 32'h3);

    // LEN strobe lands on the would-be timeout edge: 03+02+01+02 = 08.
    pushWrite(8'h00, 8'h01); pushWrite(8'h01, 8'h02); pushValid(8'h03, 8'h02);
    seq = '{8'hA5, 8'h03}; sendSeq();
    repeat (TIMEOUT_CYCLES - 2) @(posedge clk);
    #1;
    bus.RX_Data_in    = 8'h02;
    bus.RX_Data_Ready = 1'b1;
    @(posedge clk); #1;
    bus.RX_Data_Ready = 1'b0;
    @(posedge clk); #1;
    checkEqual("strobe_beats_timeout_busy", 32'(bus.Busy), 32'h1);
    seq = '{8'h01, 8'h02, 8'h08}; sendSeq();

    pushWrite(8'h00, 8'hAA);
    seq = '{8'hA5, 8'h04, 8'h03, 8'hAA}; sendSeq();
    reset = 1'b1;
    @(posedge clk); #1;
    bus.RX_Data_in    = 8'hA5;
    bus.RX_Data_Ready = 1'b1;
    @(posedge clk); #1;
    checkAllZero("midframe_reset");
    expCmd = 8'h00;
    expLen = 8'h00;
    reset  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkEqual("ready_held_busy", 32'(bus.Busy), 32'h0);
    bus.RX_Data_Ready = 1'b0;
    @(posedge clk); #1;

    // 04+01+BB = C0, so BF is rejected and C0 accepted.
    pushWrite(8'h00, 8'hBB); pushError(2'b10);
    seq = '{8'hA5, 8'h04, 8'h01, 8'hBB, 8'hBF}; sendSeq();
    pushWrite(8'h00, 8'hBB); pushValid(8'h04, 8'h01);
    seq = '{8'hA5, 8'h04, 8'h01, 8'hBB, 8'hC0}; sendSeq();

    repeat (5) @(posedge clk);
    #1;
    checkEqual("scoreboard_drained", 32'(expQ.size()), 32'h0);
    checkEqual("final_cmd", 32'(bus.Cmd_out), 32'h04);
    checkEqual("final_len", 32'(bus.Len_out), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
